// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (frame format, receiver state encoding)
// Purpose: constants and types common to the UART transmitter and receiver.
// Ports: none (package).
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // One-hot receiver states.
  typedef enum logic [5:0] {
    RX_IDLE      = 6'b000001,
    RX_START     = 6'b000010,
    RX_DATA      = 6'b000100,
    RX_STOP      = 6'b001000,
    RX_DONE      = 6'b010000,
    RX_WAIT_IDLE = 6'b100000
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for an asynchronous single-bit input
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output (second flop)
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error detect
// Purpose: recover bytes from the serial RX line.
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   data_in    - asynchronous serial line, idles high
//   byte_recv  - last good byte, held until the next good frame
//   data_valid - one-cycle pulse when byte_recv updates
//   rx_active  - high while a frame is in progress (registered)
//   frame_err  - one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [7:0] byte_recv,
  output logic       data_valid,
  output logic       rx_active,
  output logic       frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state, state_nxt;
  logic [CNT_W-1:0]          timer;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      half_hit, bit_hit;
  logic                      valid_nxt, err_nxt, active_nxt;

  uart_sync #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (rx_s)
  );

  assign half_hit = (timer == HALF_LAST);
  assign bit_hit  = (timer == BIT_LAST);

  // State register plus the bit timer / shift datapath it steers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_recv  <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_valid <= valid_nxt;
      frame_err  <= err_nxt;
      rx_active  <= active_nxt;
      if (valid_nxt) byte_recv <= shift;

      case (state)
        RX_START: timer <= half_hit ? '0 : timer + 1'b1;
        RX_DATA: begin
          timer <= bit_hit ? '0 : timer + 1'b1;
          if (bit_hit) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
          end
        end
        RX_STOP: timer <= bit_hit ? '0 : timer + 1'b1;
        default: begin
          timer   <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:      if (!rx_s) state_nxt = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START:     if (half_hit) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (bit_hit && bit_idx == IDX_LAST) state_nxt = RX_STOP;
      RX_STOP:      if (bit_hit) state_nxt = (rx_s == UART_STOP_LEVEL) ? RX_DONE : RX_WAIT_IDLE;
      RX_DONE:      state_nxt = RX_IDLE;
      // Hold off until the line returns high so a break is not re-read as frames.
      RX_WAIT_IDLE: if (rx_s) state_nxt = RX_IDLE;
      default:      state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    valid_nxt  = (state == RX_STOP) && bit_hit && (rx_s == UART_STOP_LEVEL);
    err_nxt    = (state == RX_STOP) && bit_hit && (rx_s != UART_STOP_LEVEL);
    active_nxt = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with randomized frames
module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic [7:0] byte_recv;
  logic       data_valid;
  logic       rx_active;
  logic       frame_err;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         active_cnt = 0;
  int         active_len = 0;
  bit         prev_pulse = 0;

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .byte_recv  (byte_recv),
    .data_valid (data_valid),
    .rx_active  (rx_active),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  // One 8N1 frame, LSB first; bit_ns sets the sender's baud.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int bit_ns);
    data_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      #(bit_ns);
    end
    data_in = stop_lvl;
    #(bit_ns);
  endtask

  task automatic idle_bits(input int n);
    data_in = 1'b1;
    #(n * BIT_NS);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid || frame_err) begin
        check("pulse_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
        check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, frame_err, data_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          if (!e.is_err) check("byte_recv", {24'd0, byte_recv}, {24'd0, e.data});
        end
      end
      prev_pulse = data_valid | frame_err;
      if (rx_active) active_cnt++;
      else if (active_cnt != 0) begin
        active_len = active_cnt;
        active_cnt = 0;
      end
    end else begin
      prev_pulse = 0;
      active_cnt = 0;
    end
  end

  task automatic check_held(input string name);
    check(name, {24'd0, byte_recv}, {24'd0, last_good});
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_byte"}, {24'd0, byte_recv}, 32'd0);
    check({name, "_valid"}, {31'd0, data_valid}, 32'd0);
    check({name, "_active"}, {31'd0, rx_active}, 32'd0);
    check({name, "_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    int wait_cycles;
    rst_n   = 1'b0;
    data_in = 1'b1;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(1);

    // Single clean frame.
    expect_byte(8'hA5);
    last_good = 8'hA5;
    send_frame(8'hA5, 1'b1, BIT_NS);
    idle_bits(2);
    check_held("frame_a5");
    check("rx_active_len", active_len, 152);

    // Short low glitch on an idle line.
    active_len = 0;
    data_in = 1'b0;
    #(4 * CLK_NS);
    data_in = 1'b1;
    idle_bits(3);
    check_held("glitch");
    check("glitch_active_short", {31'd0, active_len < CPB}, 32'd1);

    // Framing error followed by a held-low line, then recovery.
    expect_err();
    send_frame(8'h3C, 1'b0, BIT_NS);
    data_in = 1'b0;
    #(3 * BIT_NS);
    idle_bits(2);
    check_held("frame_err_hold");
    expect_byte(8'h5A);
    last_good = 8'h5A;
    send_frame(8'h5A, 1'b1, BIT_NS);
    idle_bits(2);
    check_held("after_err");

    // Back-to-back frames.
    expect_byte(8'h00);
    send_frame(8'h00, 1'b1, BIT_NS);
    expect_byte(8'hFF);
    send_frame(8'hFF, 1'b1, BIT_NS);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    last_good = 8'h81;
    idle_bits(2);
    check_held("back_to_back");

    // Reset in the middle of bit 4, held until the frame ends.
    fork
      send_frame(8'h77, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
      end
    join
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
    idle_bits(1);
    check_held("mid_reset_after");
    expect_byte(8'h12);
    last_good = 8'h12;
    send_frame(8'h12, 1'b1, BIT_NS);
    idle_bits(2);
    check_held("after_reset");

    // Baud tolerance around +/-3 %.
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1, BIT_NS - 5);
    idle_bits(1);
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1, BIT_NS + 5);
    last_good = 8'h55;
    idle_bits(2);
    check_held("baud_tol");

    // Randomized frames with occasional bad stop bits.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic       good;
      int         bns;
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      bns  = BIT_NS - 4 + int'($urandom_range(0, 8));
      if (good) begin
        expect_byte(b);
        last_good = b;
        send_frame(b, 1'b1, bns);
        data_in = 1'b1;
        #(int'($urandom_range(0, 2)) * BIT_NS);
      end else begin
        expect_err();
        send_frame(b, 1'b0, bns);
        data_in = 1'b0;
        #(int'($urandom_range(0, 2)) * BIT_NS);
        idle_bits(1);
      end
    end
    idle_bits(2);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 2000) begin
      @(posedge clk);
      wait_cycles++;
    end
    check_held("random_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the same 8N1 serial link driven by the team's transmitter.
- Synchronises the asynchronous serial line and detects the start-bit falling edge. Samples each bit at mid-bit and delivers one byte per frame with a single-cycle valid strobe.
- Flags framing errors and rejects glitches that look like false start bits.
- Sits between the board RX pin and the byte-consumer logic (command parser / FIFO).

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit = f_clk / baud; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), derived localparam; start-bit verification point.
- CNT_W, $clog2(CLKS_PER_BIT), derived localparam; bit-timer width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- data_in  input  1  asynchronous serial line; idles high.
- byte_recv  output  8  last correctly received byte; holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse when byte_recv is updated.
- rx_active  output  1  high while a frame is being received (START through STOP).
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; timer=0; bit index=0; shift register=0.
  - byte_recv=8'h00; data_valid=0; rx_active=0; frame_err=0.
  - Both synchroniser flops=1.
  - Reset mid-frame aborts the frame silently: no valid or error pulse, partial byte discarded.
- Input synchroniser:
  - 2 flops; rx_s = second flop.
  - All FSM decisions use rx_s only, giving 2 cycles of input latency.
- States are one-hot: IDLE, START, DATA, STOP, DONE, WAIT_IDLE.
- IDLE:
  - timer=0, index=0.
  - If rx_s=0, go to START.
- START:
  - timer increments each cycle.
  - When timer==HALF_BIT-1: if rx_s=0, go to DATA with timer=0; else go to IDLE (glitch rejected, no outputs).
- DATA:
  - timer increments.
  - When timer==CLKS_PER_BIT-1: shift[index]<=rx_s (LSB first), timer=0.
  - If index<7, index++. If index==7, index=0 and go to STOP.
- STOP:
  - When timer==CLKS_PER_BIT-1, timer=0 and sample rx_s.
  - rx_s=1: byte_recv<=shift, data_valid<=1 on the same edge; go to DONE.
  - rx_s=0: frame_err<=1 on the same edge; byte_recv unchanged; go to WAIT_IDLE.
- DONE: one cycle, then IDLE.
- WAIT_IDLE:
  - Stays while rx_s=0, which covers break conditions and prevents re-triggering on a held-low line.
  - Goes to IDLE on rx_s=1.
- rx_active: 1 in START, DATA, STOP; 0 elsewhere. Registered, so it follows the state by one cycle.
- Pulse outputs: data_valid and frame_err are never high together and never high for more than one cycle.
- Timing:
  - Samples occur at falling-edge + HALF_BIT + k*CLKS_PER_BIT (k=1..9), in synchronised time.
  - Total frame handling is about 9.5 bit periods, so a back-to-back next start bit 0.5 bit later is caught from IDLE.
- Timer never wraps: it is always cleared at CLKS_PER_BIT-1.
- Line held low forever: exactly one frame_err, then WAIT_IDLE indefinitely.

Decomposition:
- Package uart_pkg:
  - rx state enum (one-hot, 6 bits).
  - UART_DATA_BITS=8, UART_STOP_LEVEL=1'b1, UART_IDLE_LEVEL=1'b1.
  - Shared with the transmitter.
- Sub-module uart_sync:
  - 2-flop synchroniser with reset value parameter (default 1).
  - Reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16 for run time):
- Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> exactly one data_valid pulse; byte_recv=8'hA5; frame_err stays 0; rx_active high ~9.5 bit times.
- Low glitch of 4 cycles on idle line -> FSM returns to IDLE before DATA; no data_valid, no frame_err; byte_recv unchanged.
- Frame 0x3C with stop bit driven 0, line held low 3 more bits, then high -> one frame_err pulse; data_valid 0; byte_recv keeps its previous value; FSM stays in WAIT_IDLE until line high, then next frame 0x5A is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three data_valid pulses with byte_recv=00, FF, 81 in order; no frame_err.
- rst_n asserted during bit 4 of frame 0x77 -> all outputs reset to 0 next cycle; no pulse; the following clean frame 0x12 yields byte_recv=8'h12.
- Baud tolerance: 0x55 sent at CLKS_PER_BIT ±3% -> byte_recv=8'h55, no frame_err.
